// File: rtl/bus_arbiter.sv
// bus_arbiter: two-host arbiter driving a shared peripheral bus; define BUS_ARB_FIXED_PRIO_EN for fixed A priority
module bus_arbiter #(
   parameter int AW       = 24,
   parameter int DW       = 32,
   parameter int RD_DELAY = 0
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic [DW-1:0] b_rdata,
   output logic          p_clk,
   output logic [AW-1:0] p_addr,
   output logic [DW-1:0] p_wdata,
   output logic          p_wstb,
   input  logic [DW-1:0] p_rdata,
   output logic          busy,
   output logic          gnt_b
);
   typedef enum logic [1:0] {IDLE, XFER, WAIT, ACK} state_t;
   localparam logic [3:0] RD_CNT = 4'(RD_DELAY);
   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] p_addr_q, p_addr_d;
   logic [DW-1:0] p_wdata_q, p_wdata_d;
   logic [DW-1:0] a_rdata_q, a_rdata_d;
   logic [DW-1:0] b_rdata_q, b_rdata_d;
   logic          p_wstb_q, p_wstb_d;
   logic          we_q, we_d;
   logic          gnt_b_q, gnt_b_d;
   logic          win_b;
   logic          rd_smp;

   if (RD_DELAY < 0 || RD_DELAY > 15) begin : g_bad_delay
      $error("bus_arbiter: RD_DELAY %0d outside 0..15", RD_DELAY);
   end

`ifdef BUS_ARB_FIXED_PRIO_EN
   assign win_b = b_req & ~a_req;
`else
   assign win_b = b_req & (~a_req | ~gnt_b_q);
`endif

   // read data is valid exactly in the last cycle before ACK
   assign rd_smp = ~we_q & (((state_q == XFER) && (RD_CNT == 4'd0)) ||
                            ((state_q == WAIT) && (cnt_q == 4'd1)));

   assign p_clk   = i_clk;
   assign p_addr  = p_addr_q;
   assign p_wdata = p_wdata_q;
   assign p_wstb  = p_wstb_q;
   assign a_rdata = a_rdata_q;
   assign b_rdata = b_rdata_q;
   assign gnt_b   = gnt_b_q;
   assign busy    = state_q != IDLE;
   assign a_ack   = (state_q == ACK) & ~gnt_b_q;
   assign b_ack   = (state_q == ACK) & gnt_b_q;

   // next-state, grant latching, delay counting and read capture
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      p_addr_d  = p_addr_q;
      p_wdata_d = p_wdata_q;
      we_d      = we_q;
      gnt_b_d   = gnt_b_q;
      p_wstb_d  = 1'b0;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      case (state_q)
         IDLE: if (a_req | b_req) begin
            state_d   = XFER;
            gnt_b_d   = win_b;
            p_addr_d  = win_b ? b_addr : a_addr;
            p_wdata_d = win_b ? b_wdata : a_wdata;
            we_d      = win_b ? b_we : a_we;
            p_wstb_d  = win_b ? b_we : a_we;
         end
         XFER: begin
            cnt_d   = RD_CNT;
            state_d = (RD_CNT == 4'd0) ? ACK : WAIT;
         end
         WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? ACK : WAIT;
         end
         default: state_d = IDLE;
      endcase
      if (rd_smp & ~gnt_b_q) a_rdata_d = p_rdata;
      if (rd_smp & gnt_b_q) b_rdata_d = p_rdata;
   end

   // state and bus registers, cleared asynchronously
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         p_addr_q  <= '0;
         p_wdata_q <= '0;
         p_wstb_q  <= 1'b0;
         we_q      <= 1'b0;
         gnt_b_q   <= 1'b1;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         p_addr_q  <= p_addr_d;
         p_wdata_q <= p_wdata_d;
         p_wstb_q  <= p_wstb_d;
         we_q      <= we_d;
         gnt_b_q   <= gnt_b_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end
endmodule
